// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mips_pkg;

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the core control path and the multiply/divide unit.
interface mult_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
  modport slave  (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step (acc shifts right) or
// restoring divide step (acc = {remainder, dividend} shifts left).
module mdu_iter_step #(parameter int XLEN = 32) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff   = rem_sh - {1'b0, b_i};
    fits   = (rem_sh >= {1'b0, b_i});
    if (!is_div_i)
      acc_o = {sum, acc_i[XLEN-1:1]};
    else if (fits)
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    else
      acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; XLEN iterations on
// operand magnitudes, then a sign-fix cycle. busy is decoded from the state register.
module mult_div_unit #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  mdu
);
  import mips_pkg::*;

  localparam int CW = $clog2(XLEN);

  mdu_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, hi_q, lo_q;
  logic [XLEN-1:0]   hi_d, lo_d, quot, rem;
  logic [2*XLEN-1:0] prod;
  logic              div_q, neg_q, neg_rem_q, divz_q, done_q;
  logic              is_signed, is_arith, is_div, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (acc_d)
  );

  always_comb begin
    is_arith  = (mdu.op == MDU_OP_MULT) || (mdu.op == MDU_OP_MULTU) ||
                (mdu.op == MDU_OP_DIV)  || (mdu.op == MDU_OP_DIVU);
    is_signed = (mdu.op == MDU_OP_MULT) || (mdu.op == MDU_OP_DIV);
    is_div    = (mdu.op == MDU_OP_DIV)  || (mdu.op == MDU_OP_DIVU);
    a_neg     = is_signed && mdu.rs_data[XLEN-1];
    b_neg     = is_signed && mdu.rt_data[XLEN-1];
    a_mag     = a_neg ? -mdu.rs_data : mdu.rs_data;
    b_mag     = b_neg ? -mdu.rt_data : mdu.rt_data;
  end

  // Remainder keeps the dividend sign even for divide-by-zero, which yields hi = rs_data.
  always_comb begin
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    prod = neg_q ? -acc_q : acc_q;
    if (div_q) begin
      lo_d = divz_q ? '1 : (neg_q ? -quot : quot);
      hi_d = neg_rem_q ? -rem : rem;
    end else begin
      lo_d = prod[XLEN-1:0];
      hi_d = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (mdu.start && is_arith) begin
            acc_q     <= {{XLEN{1'b0}}, a_mag};
            b_q       <= b_mag;
            div_q     <= is_div;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            divz_q    <= is_div && (mdu.rt_data == '0);
            cnt_q     <= '0;
            state_q   <= MDU_CALC;
          end else if (mdu.start && mdu.op == MDU_OP_MTHI) begin
            hi_q <= mdu.rs_data;
          end else if (mdu.start && mdu.op == MDU_OP_MTLO) begin
            lo_q <= mdu.rs_data;
          end
        end
        MDU_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1))
            state_q <= MDU_FIX;
        end
        MDU_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign mdu.busy = (state_q != MDU_IDLE);
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
endmodule
